// File: rtl/auth_code_checker.sv
// -----------------------------------------------------------------------------
// auth_code_checker
//
// Purpose: collects a 4-digit code one strobe at a time, compares it against a
// fixed code table and grants a player session on a match. Three consecutive
// mismatches start a lockout period. A partial entry is discarded if the user
// stops strobing for ENTRY_TIMEOUT cycles.
//
// Optional feature: define AUTH_GUEST_EN to let code 0-0-0-0 open a guest
// session (player_id 0, is_guest 1). Without it 0-0-0-0 is an ordinary
// mismatch and is_guest is tied low.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-low reset
//   auth_digit    in   4-bit digit from the authentication switches
//   digit_strobe  in   one-cycle pulse: capture auth_digit
//   logout_req    in   one-cycle pulse: end the granted session
//   logged_in     out  high while a session is granted
//   logged_out    out  inverse of logged_in
//   player_id     out  granted ID 1-4 (guest 0), 0 when logged out
//   is_guest      out  high while a guest session is granted
//   auth_ok       out  one-cycle pulse on grant
//   auth_fail     out  one-cycle pulse on a mismatched code
//   locked_out    out  high during lockout
//   attempts_left out  remaining tries before lockout (3..0)
//   digit_count   out  digits captured in the current entry (0-4)
//   dbg_state_o   out  current FSM state encoding, for observation only
//
// Handshake: digit_strobe and logout_req are single-cycle pulses sampled on the
// rising edge; there is no back-pressure, a strobe arriving in a state that
// does not accept it is dropped.
// -----------------------------------------------------------------------------
module auth_code_checker #(
  parameter int unsigned ENTRY_TIMEOUT  = 100000000,
  parameter int unsigned LOCKOUT_CYCLES = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] auth_digit,
  input  logic       digit_strobe,
  input  logic       logout_req,
  output logic       logged_in,
  output logic       logged_out,
  output logic [2:0] player_id,
  output logic       is_guest,
  output logic       auth_ok,
  output logic       auth_fail,
  output logic       locked_out,
  output logic [1:0] attempts_left,
  output logic [2:0] digit_count,
  output logic [2:0] dbg_state_o
);

  localparam int GAP_W  = (ENTRY_TIMEOUT  > 1) ? $clog2(ENTRY_TIMEOUT + 1)  : 1;
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(ENTRY_TIMEOUT - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_GRANTED = 3'd3,
    S_LOCKED  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [11:0]        code_q, code_d;      // first three digits, oldest in the top nibble
  logic [2:0]         count_q, count_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [LOCK_W-1:0]  lock_q, lock_d;
  logic [1:0]         attempts_q, attempts_d;
  logic               match_q, match_d;
  logic [2:0]         id_q, id_d;
  logic [3:0]         hit;                 // {match, id} for the code being completed

  // Code table lookup. Returns {match, player_id}. The guest code is the only
  // match carrying player_id 0, which is how is_guest is recognised later.
  function automatic logic [3:0] lookup(input logic [15:0] code);
    logic [3:0] r;
    r = 4'b0_000;
    case (code)
      16'h3141: r = 4'b1_001;
      16'h2718: r = 4'b1_010;
      16'h1618: r = 4'b1_011;
      16'h0577: r = 4'b1_100;
`ifdef AUTH_GUEST_EN
      16'h0000: r = 4'b1_000;
`endif
      default:  r = 4'b0_000;
    endcase
    return r;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      lock_q     <= '0;
      attempts_q <= 2'd3;
      match_q    <= 1'b0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      lock_q     <= lock_d;
      attempts_q <= attempts_d;
      match_q    <= match_d;
      id_q       <= id_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    count_d    = count_q;
    gap_d      = gap_q;
    lock_d     = lock_q;
    attempts_d = attempts_q;
    match_d    = match_q;
    id_d       = id_q;
    hit        = lookup({code_q, auth_digit});

    unique case (state_q)
      S_IDLE: begin
        if (digit_strobe) begin
          code_d  = {8'h00, auth_digit};
          count_d = 3'd1;
          gap_d   = '0;
          state_d = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (digit_strobe) begin
          count_d = count_q + 3'd1;
          gap_d   = '0;
          if (count_q == 3'd3) begin
            // Fourth digit: resolve the result now so CHECK can present it
            // combinationally in the very next cycle.
            match_d    = hit[3];
            id_d       = hit[2:0];
            attempts_d = hit[3] ? 2'd3 : (attempts_q - 2'd1);
            state_d    = S_CHECK;
          end else begin
            code_d = {code_q[7:0], auth_digit};
          end
        end else if (gap_q >= GAP_LAST) begin
          // Abandoned entry: drop it without charging an attempt.
          count_d = '0;
          gap_d   = '0;
          code_d  = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_CHECK: begin
        count_d = '0;
        code_d  = '0;
        if (match_q) begin
          state_d = S_GRANTED;
        end else if (attempts_q == 2'd0) begin
          lock_d  = '0;
          state_d = S_LOCKED;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_GRANTED: begin
        if (logout_req) begin
          id_d    = '0;
          match_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_LOCKED: begin
        if (lock_q >= LOCK_LAST) begin
          lock_d     = '0;
          attempts_d = 2'd3;
          match_d    = 1'b0;
          id_d       = '0;
          state_d    = S_IDLE;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. The CHECK cycle already shows the grant, so logged_in rises
  // together with auth_ok.
  always_comb begin
    logged_in     = (state_q == S_GRANTED) || ((state_q == S_CHECK) && match_q);
    logged_out    = ~logged_in;
    player_id     = logged_in ? id_q : 3'd0;
`ifdef AUTH_GUEST_EN
    is_guest      = logged_in && (id_q == 3'd0);
`else
    is_guest      = 1'b0;
`endif
    auth_ok       = (state_q == S_CHECK) && match_q;
    auth_fail     = (state_q == S_CHECK) && !match_q;
    locked_out    = (state_q == S_LOCKED);
    attempts_left = attempts_q;
    digit_count   = count_q;
    dbg_state_o   = state_q;
  end

endmodule

// File: tb/tb_auth_code_checker.sv
module tb_auth_code_checker;

  localparam int TMO  = 10;
  localparam int LOCK = 20;

  logic       clk;
  logic       rst;
  logic [3:0] auth_digit;
  logic       digit_strobe;
  logic       logout_req;
  logic       logged_in;
  logic       logged_out;
  logic [2:0] player_id;
  logic       is_guest;
  logic       auth_ok;
  logic       auth_fail;
  logic       locked_out;
  logic [1:0] attempts_left;
  logic [2:0] digit_count;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int m_att  = 3;   // reference model: attempts remaining

  auth_code_checker #(.ENTRY_TIMEOUT(TMO), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk(clk), .rst(rst), .auth_digit(auth_digit), .digit_strobe(digit_strobe),
    .logout_req(logout_req), .logged_in(logged_in), .logged_out(logged_out),
    .player_id(player_id), .is_guest(is_guest), .auth_ok(auth_ok),
    .auth_fail(auth_fail), .locked_out(locked_out), .attempts_left(attempts_left),
    .digit_count(digit_count), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference code table
  logic [15:0] tbl_code [5] = '{16'h3141, 16'h2718, 16'h1618, 16'h0577, 16'h0000};
  int          tbl_id   [5] = '{1, 2, 3, 4, 0};
`ifdef AUTH_GUEST_EN
  localparam int N_TBL = 5;
`else
  localparam int N_TBL = 4;
`endif

  function automatic int model_id(input logic [15:0] c);
    for (int i = 0; i < N_TBL; i++)
      if (tbl_code[i] == c) return tbl_id[i];
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_logged_in"},  logged_in, 0);
    chk({tag, "_logged_out"}, logged_out, 1);
    chk({tag, "_player_id"},  player_id, 0);
    chk({tag, "_is_guest"},   is_guest, 0);
    chk({tag, "_auth_ok"},    auth_ok, 0);
    chk({tag, "_auth_fail"},  auth_fail, 0);
    chk({tag, "_locked_out"}, locked_out, 0);
    chk({tag, "_attempts"},   attempts_left, 3);
    chk({tag, "_count"},      digit_count, 0);
  endtask

  // driver tasks: inputs change on the falling edge, outputs are sampled there too
  task automatic strobe(input logic [3:0] d);
    @(negedge clk);
    auth_digit   = d;
    digit_strobe = 1'b1;
    @(negedge clk);
    digit_strobe = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c, input int gap);
    logic [15:0] v;
    v = c;
    for (int i = 0; i < 4; i++) begin
      strobe(v[15:12]);
      v = v << 4;
      if (i < 3) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_logout(input string tag);
    @(negedge clk);
    logout_req = 1'b1;
    @(negedge clk);
    logout_req = 1'b0;
    chk({tag, "_lo_logged_in"},  logged_in, 0);
    chk({tag, "_lo_logged_out"}, logged_out, 1);
    chk({tag, "_lo_player_id"},  player_id, 0);
    chk({tag, "_lo_is_guest"},   is_guest, 0);
  endtask

  // Called at the falling edge right after the fourth digit was captured.
  task automatic expect_result(input logic [15:0] c, input string tag, output bit granted);
    int id;
    int n;
    id = model_id(c);
    granted = (id >= 0);
    if (granted) begin
      m_att = 3;
      chk({tag, "_auth_ok"},    auth_ok, 1);
      chk({tag, "_auth_fail"},  auth_fail, 0);
      chk({tag, "_logged_in"},  logged_in, 1);
      chk({tag, "_player_id"},  player_id, id);
      chk({tag, "_is_guest"},   is_guest, (id == 0));
      chk({tag, "_attempts"},   attempts_left, 3);
      @(negedge clk);
      chk({tag, "_ok_pulse"},   auth_ok, 0);
      chk({tag, "_held"},       logged_in, 1);
      chk({tag, "_count0"},     digit_count, 0);
    end else begin
      m_att--;
      chk({tag, "_auth_fail"},  auth_fail, 1);
      chk({tag, "_auth_ok"},    auth_ok, 0);
      chk({tag, "_logged_in"},  logged_in, 0);
      chk({tag, "_attempts"},   attempts_left, m_att);
      if (m_att == 0) begin
        n = 0;
        @(negedge clk);
        while (locked_out && n < 10 * LOCK) begin
          n++;
          @(negedge clk);
        end
        chk({tag, "_lock_len"},   n, LOCK);
        chk({tag, "_lock_att"},   attempts_left, 3);
        m_att = 3;
      end else begin
        @(negedge clk);
        chk({tag, "_fail_pulse"}, auth_fail, 0);
        chk({tag, "_count0"},     digit_count, 0);
        chk({tag, "_no_lock"},    locked_out, 0);
      end
    end
  endtask

  initial begin
    bit          g;
    logic [15:0] c;
    int          gap;

    rst = 1'b0; auth_digit = '0; digit_strobe = 1'b0; logout_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;

    // 3-1-4-1 grants player 1
    enter_code(16'h3141, 0);
    expect_result(16'h3141, "id1", g);
    do_logout("id1");

    // partial entry abandoned by the timeout
    strobe(4'd2);
    strobe(4'd7);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_before", digit_count, 2);
    @(negedge clk);
    chk("tmo_count", digit_count, 0);
    chk("tmo_nofail", auth_fail, 0);
    chk("tmo_att", attempts_left, 3);
    enter_code(16'h2718, 1);
    expect_result(16'h2718, "id2", g);
    do_logout("id2");

    // logout and strobe together while granted as ID4
    enter_code(16'h0577, 0);
    expect_result(16'h0577, "id4", g);
    @(negedge clk);
    logout_req = 1'b1; digit_strobe = 1'b1; auth_digit = 4'd3;
    @(negedge clk);
    logout_req = 1'b0; digit_strobe = 1'b0;
    chk("both_logged_out", logged_out, 1);
    chk("both_player_id", player_id, 0);
    chk("both_count", digit_count, 0);
    @(negedge clk);
    chk("both_count_after", digit_count, 0);

    // three failures lead to lockout
    for (int i = 0; i < 3; i++) begin
      enter_code(16'h9999, 0);
      expect_result(16'h9999, "fail9", g);
    end

    // reset mid-entry
    strobe(4'd1);
    strobe(4'd6);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_entry");
    rst = 1'b1;

    // reset mid-lockout
    for (int i = 0; i < 2; i++) begin
      enter_code(16'hABCD, 0);
      expect_result(16'hABCD, "pre_lock", g);
    end
    enter_code(16'hABCD, 0);
    chk("lock3_fail", auth_fail, 1);
    repeat (5) @(negedge clk);
    chk("lock3_active", locked_out, 1);
    auth_digit = 4'd3; digit_strobe = 1'b1;
    @(negedge clk);
    digit_strobe = 1'b0;
    chk("lock3_strobe_ign", digit_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_lock");
    rst = 1'b1;
    m_att = 3;

    // guest code (outcome depends on the build option)
    enter_code(16'h0000, 0);
    expect_result(16'h0000, "guest", g);
    if (g) do_logout("guest");

    // randomized entries against the reference model
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) c = tbl_code[$urandom_range(0, 4)];
      else                           c = 16'($urandom);
      gap = $urandom_range(0, 3);
      enter_code(c, gap);
      expect_result(c, $sformatf("rnd%0d", k), g);
      if (g) do_logout($sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/auth_code_checker.md
AUTH_CODE_CHECKER -- requirements
Module: auth_code_checker

Interface
REQ-001 SHALL have parameter ENTRY_TIMEOUT, default 100000000, meaning max cycles allowed between digit strobes before the partial code is discarded.
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 250000000, meaning cycles spent in lockout after three consecutive failures.
REQ-003 SHALL have a single clock and a synchronous, active-low reset (ports clk, rst); no other clock or asynchronous reset.
REQ-004 Ports, one per line (name direction width meaning):
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset.
- auth_digit  input  4  code digit from the authentication switches.
- digit_strobe  input  1  one-cycle pulse from the shaped button; capture auth_digit.
- logout_req  input  1  one-cycle pulse; ends the session.
- logged_in  output  1  high only while a session is granted.
- logged_out  output  1  always the inverse of logged_in.
- player_id  output  3  granted ID 1-4, guest 0, 0 when logged out.
- is_guest  output  1  high while a guest session is granted.
- auth_ok  output  1  one-cycle pulse on grant.
- auth_fail  output  1  one-cycle pulse on a mismatched 4-digit code.
- locked_out  output  1  high during lockout.
- attempts_left  output  2  remaining tries before lockout (3..0).
- digit_count  output  3  digits captured in the current entry (0-4).

Function
REQ-005 States SHALL be IDLE, ENTRY, CHECK, GRANTED, LOCKED.
REQ-006 Code table: ID1 = 3-1-4-1; ID2 = 2-7-1-8; ID3 = 1-6-1-8; ID4 = 0-5-7-7; guest = 0-0-0-0. Digits are compared in entry order.
REQ-007 In IDLE, digit_strobe SHALL store auth_digit as digit 1, set digit_count to 1 and go to ENTRY.
REQ-008 In ENTRY, each digit_strobe SHALL store the next digit and increment digit_count; the strobe capturing digit 4 moves to CHECK on the next edge.
REQ-009 Digit values 10-15 SHALL be captured normally and can never match the table.
REQ-010 In CHECK (exactly one cycle), a match SHALL go to GRANTED, pulse auth_ok, set player_id/is_guest and reload attempts_left to 3.
REQ-011 In CHECK, a mismatch SHALL pulse auth_fail and decrement attempts_left. It goes to LOCKED if attempts_left reaches 0, else to IDLE. digit_count returns to 0.
REQ-012 Latency: auth_ok/auth_fail are asserted in the cycle after the edge that captured digit 4; logged_in rises on the same edge as auth_ok.
REQ-013 In ENTRY, an inter-strobe gap of ENTRY_TIMEOUT cycles SHALL discard the partial entry and return to IDLE with digit_count 0 and no failure counted.
REQ-014 In GRANTED, logout_req SHALL return to IDLE with player_id 0 and is_guest 0. A simultaneous digit_strobe is ignored.
REQ-015 digit_strobe SHALL be ignored in CHECK, GRANTED and LOCKED. logout_req SHALL be ignored outside GRANTED.
REQ-016 LOCKED SHALL assert locked_out for exactly LOCKOUT_CYCLES cycles, then go to IDLE with attempts_left 3.
REQ-017 Timeout and lockout counters SHALL saturate without wrapping and SHALL be sized from their parameters.

Reset
REQ-018 With rst low at a clock edge, the block SHALL enter IDLE.
REQ-019 Reset values: logged_in 0, logged_out 1, player_id 0, is_guest 0, auth_ok 0, auth_fail 0, locked_out 0, attempts_left 3, digit_count 0; all stored digits and counters cleared.
REQ-020 Reset SHALL take priority over every input in every state, including mid-entry and mid-lockout.

Configuration
REQ-021 Macro AUTH_GUEST_EN defined: code 0-0-0-0 SHALL grant a guest session (player_id 0, is_guest 1).
REQ-022 AUTH_GUEST_EN undefined: 0-0-0-0 SHALL be an ordinary mismatch, and is_guest SHALL be tied to 0.

Verification
REQ-023 Strobe 3,1,4,1 -> auth_ok pulse one cycle after the 4th strobe; logged_in=1, player_id=1, attempts_left=3.
REQ-024 Three entries of 9,9,9,9 -> three auth_fail pulses; attempts_left steps 2,1,0; locked_out=1 for LOCKOUT_CYCLES (test override 20), then IDLE with attempts_left=3.
REQ-025 Strobe 2,7 then idle ENTRY_TIMEOUT cycles (override 10) -> digit_count 0, no auth_fail; a following 2,7,1,8 grants player_id=2.
REQ-026 Granted as ID4 with logout_req and digit_strobe in the same cycle -> logged_out=1, player_id=0, digit_count stays 0.
REQ-027 0,0,0,0 -> with AUTH_GUEST_EN: auth_ok, is_guest=1; without it: auth_fail, attempts_left=2.
REQ-028 rst low after two strobes and again mid-lockout -> all outputs at reset values on the next edge.
